mem_xbar: RTL and testbench
===========================

MEM_XBAR -- requirements
Module: mem_xbar

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  NUM_M, 3, number of masters (0 = I-fetch refill, 1 = D-cache read, 2 = D-cache writeback).
  NUM_S, 2, number of slave regions.
  ADDR_W, 32, address width.
  DATA_W, 128, cache-line data width.
  SLV_BASE, {32'h1000_0000, 32'h0000_0000}, per-slave base address, packed with slave 0 in the LSBs.
  SLV_SIZE, {32'h1000_0000, 32'h1000_0000}, per-slave region size, each a power of two.
  TIMEOUT, 256, maximum number of WAIT cycles before an error response.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
  clk  in  1  single clock.
  rst  in  1  reset, synchronous, active-high.
  m_req  in  NUM_M  per-master request level.
  m_we  in  NUM_M  per-master write flag.
  m_addr  in  NUM_M*ADDR_W  per-master address.
  m_wdata  in  NUM_M*DATA_W  per-master write line.
  m_ready  out  NUM_M  per-master one-cycle completion pulse.
  m_err  out  NUM_M  per-master error flag, valid with m_ready.
  m_rdata  out  DATA_W  shared read line, valid with m_ready.
  s_req  out  NUM_S  per-slave request level.
  s_we  out  1  shared write flag.
  s_addr  out  ADDR_W  region offset (address minus slave base).
  s_wdata  out  DATA_W  shared write line.
  s_rdata  in  NUM_S*DATA_W  per-slave read line.
  s_ready  in  NUM_S  per-slave one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have three states, IDLE, WAIT and RESP; only one transaction SHALL be outstanding at a time.
REQ-004 In IDLE, when any m_req bit is high, the block SHALL select a winner by round-robin starting at pointer rr_ptr, then latch that master's index, we, addr and wdata.
REQ-005 After a grant to master i, rr_ptr SHALL become (i+1) mod NUM_M.
REQ-006 Slave j SHALL be hit when (addr & ~(SLV_SIZE[j]-1)) == SLV_BASE[j]; if several slaves hit, the lowest j SHALL win.
REQ-007 On a hit, the block SHALL go IDLE->WAIT, driving s_req[j]=1, s_we, s_addr=addr-SLV_BASE[j] and s_wdata from the latched values, all stable for the whole of WAIT.
REQ-008 On a miss, the block SHALL go IDLE->RESP with error set, and SHALL not assert any s_req.
REQ-009 In WAIT, s_ready[j] sampled high SHALL latch s_rdata[j] (or zero on a write) and move the FSM to RESP; s_req SHALL then be low in RESP.
REQ-010 In WAIT, a cycle counter SHALL run; when it reaches TIMEOUT-1 without s_ready, the block SHALL go to RESP with error set and s_req dropped.
REQ-011 s_ready SHALL be ignored outside WAIT, and s_ready on any non-selected slave SHALL be ignored.
REQ-012 RESP SHALL last exactly one cycle with m_ready[i]=1, m_err[i]=error, and m_rdata=latched line (zero on error or write); the next state SHALL be IDLE.
REQ-013 Latency: request seen in IDLE at cycle 0 -> s_req at cycle 1; s_ready at cycle n -> m_ready at cycle n+1; a miss SHALL give m_ready at cycle 1.
REQ-014 Masters SHALL hold m_req, m_addr and m_wdata until m_ready and drop m_req on the following cycle; a master that is already granted SHALL not be re-granted by a request still held during RESP.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 When rst is high at a clk edge, the block SHALL go to IDLE, set rr_ptr=0, clear the counter, and drive m_ready, m_err, m_rdata, s_req, s_we, s_addr and s_wdata to 0.
REQ-017 A reset during WAIT SHALL abandon the transaction: no m_ready SHALL be issued, and a late s_ready SHALL be ignored.

Structure
REQ-018 Package xbar_pkg SHALL hold the FSM state enum, default NUM_M, NUM_S, ADDR_W and DATA_W, and the region-hit function.
REQ-019 The arbiter SHALL be a sub-module rr_arbiter (NUM_M request bits, pointer in, one-hot grant plus index out); decode and the FSM SHALL stay in mem_xbar.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults unless stated):
  Master 2 reads 0x1000_0040; slave 1 returns 0xA5..A5 with s_ready 3 cycles after s_req -> s_addr=0x0000_0040, m_ready[2] pulses once at cycle 5, m_err=0, m_rdata=0xA5..A5.
  All three m_req held from cycle 0 -> grants in order 0, 1, 2; a new request by all three then goes to master 0.
  Master 0 accesses 0x2000_0000 (unmapped) -> s_req stays 0; m_ready[0]=1 and m_err[0]=1 at cycle 1; m_rdata=0.
  TIMEOUT=16, slave 0 never ready -> s_req[0] high for exactly 16 cycles, then m_ready=1 and m_err=1; a late s_ready is ignored.
  rst asserted during WAIT -> s_req=0 after that edge, no m_ready, rr_ptr=0; the next request is from master 0 and succeeds.
  Master 1 writes 0x0000_0100 with wdata 0x0123..CDEF -> s_req[0]=1, s_we=1, s_wdata matches; response has m_rdata=0 and m_err=0.

Source files
------------

// File: rtl/mem_xbar_pkg.sv
// Shared types, default sizes and the address-region decode for the memory crossbar.
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } xbar_state_e;

    localparam int XBAR_NUM_M  = 3;
    localparam int XBAR_NUM_S  = 2;
    localparam int XBAR_ADDR_W = 32;
    localparam int XBAR_DATA_W = 128;

    // Operands are zero-extended to 64 bits so one function serves any ADDR_W up to 64.
    function automatic logic region_hit(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input logic [63:0] size);
        return (addr & ~(size - 64'd1)) == base;
    endfunction

endpackage

// File: rtl/mem_xbar_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr, wrapping at NUM_M, and grants the first requester.
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter int  NUM_M = XBAR_NUM_M,
    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_M-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = ptr;
        for (int k = 0; k < NUM_M; k++) begin
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
            cand = (cand == IDX_W'(NUM_M - 1)) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/mem_xbar.sv
// Single-outstanding cache-line crossbar: round-robin masters onto address-decoded slave regions.
//   state | meaning
//   IDLE  | arbitrate, decode and launch (miss goes straight to RESP)
//   WAIT  | s_req held to the selected slave, timeout counter running
//   RESP  | one-cycle m_ready/m_err/m_rdata pulse to the granted master
module mem_xbar
    import xbar_pkg::*;
#(
    parameter int                          NUM_M    = XBAR_NUM_M,
    parameter int                          NUM_S    = XBAR_NUM_S,
    parameter int                          ADDR_W   = XBAR_ADDR_W,
    parameter int                          DATA_W   = XBAR_DATA_W,
    parameter logic [NUM_S*ADDR_W-1:0]     SLV_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_S*ADDR_W-1:0]     SLV_SIZE = {32'h1000_0000, 32'h1000_0000},
    parameter int                          TIMEOUT  = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_req,
    input  logic [NUM_M-1:0]          m_we,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr,
    input  logic [NUM_M*DATA_W-1:0]   m_wdata,
    output logic [NUM_M-1:0]          m_ready,
    output logic [NUM_M-1:0]          m_err,
    output logic [DATA_W-1:0]         m_rdata,
    output logic [NUM_S-1:0]          s_req,
    output logic                      s_we,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic [NUM_S*DATA_W-1:0]   s_rdata,
    input  logic [NUM_S-1:0]          s_ready
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    xbar_state_e       state_q,   state_d;
    logic [IDX_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [NUM_M-1:0]  mst_q,     mst_d;
    logic [NUM_M-1:0]  served_q,  served_d;
    logic [NUM_M-1:0]  m_ready_q, m_ready_d;
    logic [NUM_M-1:0]  m_err_q,   m_err_d;
    logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
    logic [NUM_S-1:0]  s_req_q,   s_req_d;
    logic              s_we_q,    s_we_d;
    logic [ADDR_W-1:0] s_addr_q,  s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;

    logic [NUM_M-1:0]  arb_req;
    logic [NUM_M-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic [NUM_S-1:0]  hit_oh;
    logic [ADDR_W-1:0] hit_base;
    logic [DATA_W-1:0] rd_sel;
    logic              ready_hit;

    // The master just served may still hold m_req for a cycle after RESP; keep it out of that arbitration.
    assign arb_req = (state_q == IDLE) ? (m_req & ~served_q) : '0;

    rr_arbiter #(.NUM_M(NUM_M)) u_arb (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt[i]) begin
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_we    = m_we[i];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Walk down so the lowest matching region is the one left standing.
    always_comb begin
        hit_oh   = '0;
        hit_base = '0;
        for (int j = NUM_S - 1; j >= 0; j--) begin
            if (region_hit(64'(sel_addr),
                           64'(SLV_BASE[j*ADDR_W +: ADDR_W]),
                           64'(SLV_SIZE[j*ADDR_W +: ADDR_W]))) begin
                hit_oh    = '0;
                hit_oh[j] = 1'b1;
                hit_base  = SLV_BASE[j*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int j = 0; j < NUM_S; j++) begin
            if (s_req_q[j]) rd_sel = s_rdata[j*DATA_W +: DATA_W];
        end
    end

    assign ready_hit = |(s_req_q & s_ready);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        mst_d     = mst_q;
        served_d  = '0;
        m_ready_d = '0;
        m_err_d   = '0;
        m_rdata_d = '0;
        s_req_d   = s_req_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    mst_d    = gnt;
                    rr_ptr_d = (gnt_idx == IDX_W'(NUM_M - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d    = '0;
                    if (|hit_oh) begin
                        state_d   = WAIT;
                        s_req_d   = hit_oh;
                        s_we_d    = sel_we;
                        s_addr_d  = sel_addr - hit_base;
                        s_wdata_d = sel_wdata;
                    end else begin
                        state_d   = RESP;
                        m_ready_d = gnt;
                        m_err_d   = gnt;
                    end
                end
            end
            WAIT: begin
                if (ready_hit) begin
                    state_d   = RESP;
                    s_req_d   = '0;
                    m_ready_d = mst_q;
                    m_rdata_d = s_we_q ? '0 : rd_sel;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    s_req_d   = '0;
                    m_ready_d = mst_q;
                    m_err_d   = mst_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d  = IDLE;
                served_d = mst_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            mst_q     <= '0;
            served_q  <= '0;
            m_ready_q <= '0;
            m_err_q   <= '0;
            m_rdata_q <= '0;
            s_req_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            mst_q     <= mst_d;
            served_q  <= served_d;
            m_ready_q <= m_ready_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
            s_req_q   <= s_req_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
        end
    end

    assign m_ready = m_ready_q;
    assign m_err   = m_err_q;
    assign m_rdata = m_rdata_q;
    assign s_req   = s_req_q;
    assign s_we    = s_we_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_mem_xbar.sv
// Bench for mem_xbar: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_xbar;

    localparam int NUM_M   = 3;
    localparam int NUM_S   = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_M-1:0]        m_req = '0;
    logic [NUM_M-1:0]        m_we = '0;
    logic [NUM_M*ADDR_W-1:0] m_addr = '0;
    logic [NUM_M*DATA_W-1:0] m_wdata = '0;
    logic [NUM_M-1:0]        m_ready;
    logic [NUM_M-1:0]        m_err;
    logic [DATA_W-1:0]       m_rdata;
    logic [NUM_S-1:0]        s_req;
    logic                    s_we;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic [NUM_S*DATA_W-1:0] s_rdata = '0;
    logic [NUM_S-1:0]        s_ready = '0;

    mem_xbar #(
        .NUM_M   (NUM_M),
        .NUM_S   (NUM_S),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SLV_BASE({32'h1000_0000, 32'h0000_0000}),
        .SLV_SIZE({32'h1000_0000, 32'h1000_0000}),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] t_addr  [NUM_M];
    logic              t_we    [NUM_M];
    logic [DATA_W-1:0] t_wdata [NUM_M];
    logic [DATA_W-1:0] sl_data [NUM_S];
    logic [ADDR_W-1:0] map_base [NUM_S];
    logic [ADDR_W-1:0] map_size [NUM_S];

    // Per-transaction observations, in completion order.
    int                n_done;
    bit                o_glitch;
    logic [NUM_M-1:0]  o_rdy_vec [3];
    logic [NUM_M-1:0]  o_err     [3];
    logic [DATA_W-1:0] o_rdata   [3];
    int                o_rdy     [3];
    logic [NUM_S-1:0]  o_sreq    [3];
    int                o_first   [3];
    int                o_cnt     [3];
    logic [ADDR_W-1:0] o_saddr   [3];
    logic              o_swe     [3];
    logic [DATA_W-1:0] o_swdata  [3];

    function automatic logic [DATA_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Acts as the requesting masters and the slaves: cycle 0 is the first cycle m_req is high.
    // lat = cycles from first s_req to the s_ready pulse, -1 for a slave that never answers.
    task automatic run_txn(input logic [NUM_M-1:0] reqs, input int lat, input int budget);
        logic [NUM_M-1:0]  pend, drop;
        logic [NUM_S-1:0]  prev_sreq, cur_sreq;
        logic [ADDR_W-1:0] cur_addr;
        logic              cur_we;
        logic [DATA_W-1:0] cur_wdata;
        int                c, start, cur_first, cur_cnt;
        pend = reqs; drop = '0; prev_sreq = '0; cur_sreq = '0;
        cur_addr = '0; cur_we = 1'b0; cur_wdata = '0;
        start = -1; cur_first = -1; cur_cnt = 0; n_done = 0; o_glitch = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NUM_M; i++) begin
            m_addr[i*ADDR_W +: ADDR_W]  = t_addr[i];
            m_we[i]                     = t_we[i];
            m_wdata[i*DATA_W +: DATA_W] = t_wdata[i];
        end
        for (int j = 0; j < NUM_S; j++) s_rdata[j*DATA_W +: DATA_W] = sl_data[j];
        m_req = pend;
        c = 0;
        while (pend != '0 && c < budget) begin
            @(posedge clk); #1;
            c++;
            m_req = m_req & ~drop;
            drop = '0;
            s_ready = '0;
            if (s_req != '0) begin
                if (prev_sreq == '0) begin
                    start = c; cur_first = c; cur_sreq = s_req;
                    cur_addr = s_addr; cur_we = s_we; cur_wdata = s_wdata; cur_cnt = 0;
                end else if (s_req !== cur_sreq || s_addr !== cur_addr ||
                             s_we !== cur_we || s_wdata !== cur_wdata) begin
                    o_glitch = 1'b1;
                end
                cur_cnt++;
                if (lat >= 0 && c == start + lat) s_ready = s_req;
            end
            prev_sreq = s_req;
            if (m_ready != '0) begin
                if ($countones(m_ready) != 1) o_glitch = 1'b1;
                if (n_done < 3) begin
                    o_rdy_vec[n_done] = m_ready;
                    o_err[n_done]     = m_err;
                    o_rdata[n_done]   = m_rdata;
                    o_rdy[n_done]     = c;
                    o_sreq[n_done]    = cur_sreq;
                    o_first[n_done]   = cur_first;
                    o_cnt[n_done]     = cur_cnt;
                    o_saddr[n_done]   = cur_addr;
                    o_swe[n_done]     = cur_we;
                    o_swdata[n_done]  = cur_wdata;
                end
                n_done++;
                pend = pend & ~m_ready;
                drop = m_ready;
                cur_sreq = '0; cur_first = -1; cur_cnt = 0;
                cur_addr = '0; cur_we = 1'b0; cur_wdata = '0;
            end
        end
        if (pend != '0) begin
            checks++; errors++;
            $display("FAIL txn_budget: pending masters %b still waiting after %0d cycles", pend, c);
        end
        @(posedge clk); #1;
        m_req = m_req & ~drop;
        s_ready = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_ready !== '0 || m_err !== '0 || m_rdata !== '0) begin
            errors++;
            $display("FAIL reset_master_side: m_ready=%b m_err=%b m_rdata=%h, required all zero", m_ready, m_err, m_rdata);
        end
        checks++;
        if (s_req !== '0 || s_we !== 1'b0 || s_addr !== '0 || s_wdata !== '0) begin
            errors++;
            $display("FAIL reset_slave_side: s_req=%b s_we=%b s_addr=%h s_wdata=%h, required all zero", s_req, s_we, s_addr, s_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_slave1();
        t_addr[2] = 32'h1000_0040; t_we[2] = 1'b0; t_wdata[2] = '0;
        sl_data[0] = '0; sl_data[1] = {16{8'hA5}};
        run_txn(3'b100, 3, 50);
        checks++;
        if (n_done !== 1 || o_rdy_vec[0] !== 3'b100 || o_err[0] !== 3'b000) begin
            errors++;
            $display("FAIL read_resp: done=%0d ready=%b err=%b, required 1 100 000", n_done, o_rdy_vec[0], o_err[0]);
        end
        checks++;
        if (o_sreq[0] !== 2'b10 || o_saddr[0] !== 32'h0000_0040 || o_first[0] != 1) begin
            errors++;
            $display("FAIL read_slave_side: s_req=%b s_addr=%h cycle=%0d, required 10 00000040 1", o_sreq[0], o_saddr[0], o_first[0]);
        end
        checks++;
        if (o_rdy[0] != 5 || o_rdata[0] !== {16{8'hA5}}) begin
            errors++;
            $display("FAIL read_timing_data: cycle=%0d rdata=%h, required 5 a5..a5", o_rdy[0], o_rdata[0]);
        end
        checks++;
        if (m_ready !== '0 || o_glitch) begin
            errors++;
            $display("FAIL read_single_pulse: m_ready=%b glitch=%0d, required 000 0", m_ready, o_glitch);
        end
    endtask

    task automatic test_rr_order();
        for (int i = 0; i < NUM_M; i++) begin
            t_addr[i] = 32'h0000_1000 + 32'(i * 16); t_we[i] = 1'b0; t_wdata[i] = '0;
        end
        sl_data[0] = rnd_line();
        for (int pass = 0; pass < 2; pass++) begin
            run_txn(3'b111, 1, 100);
            checks++;
            if (n_done != 3 || o_rdy_vec[0] !== 3'b001 || o_rdy_vec[1] !== 3'b010 || o_rdy_vec[2] !== 3'b100) begin
                errors++;
                $display("FAIL rr_order pass %0d: done=%0d order=%b,%b,%b, required 3 001,010,100",
                         pass, n_done, o_rdy_vec[0], o_rdy_vec[1], o_rdy_vec[2]);
            end
        end
    endtask

    task automatic test_unmapped();
        t_addr[0] = 32'h2000_0000; t_we[0] = 1'b0; t_wdata[0] = '0;
        run_txn(3'b001, 0, 20);
        checks++;
        if (n_done != 1 || o_rdy_vec[0] !== 3'b001 || o_err[0] !== 3'b001 || o_rdy[0] != 1) begin
            errors++;
            $display("FAIL unmapped_resp: done=%0d ready=%b err=%b cycle=%0d, required 1 001 001 1",
                     n_done, o_rdy_vec[0], o_err[0], o_rdy[0]);
        end
        checks++;
        if (o_cnt[0] != 0 || o_rdata[0] !== '0) begin
            errors++;
            $display("FAIL unmapped_no_sreq: s_req cycles=%0d rdata=%h, required 0 0", o_cnt[0], o_rdata[0]);
        end
    endtask

    task automatic test_timeout();
        bit stray;
        t_addr[0] = 32'h0000_0080; t_we[0] = 1'b0; t_wdata[0] = '0;
        run_txn(3'b001, -1, 60);
        checks++;
        if (o_sreq[0] !== 2'b01 || o_cnt[0] != TIMEOUT || o_first[0] != 1) begin
            errors++;
            $display("FAIL timeout_sreq: s_req=%b high=%0d first=%0d, required 01 %0d 1", o_sreq[0], o_cnt[0], o_first[0], TIMEOUT);
        end
        checks++;
        if (n_done != 1 || o_rdy[0] != TIMEOUT + 1 || o_err[0] !== 3'b001 || o_rdata[0] !== '0) begin
            errors++;
            $display("FAIL timeout_resp: done=%0d cycle=%0d err=%b rdata=%h, required 1 %0d 001 0",
                     n_done, o_rdy[0], o_err[0], o_rdata[0], TIMEOUT + 1);
        end
        stray = 1'b0;
        s_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            s_ready = '0;
            if (m_ready != '0 || s_req != '0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL timeout_late_ready: response or s_req seen after late s_ready, required none");
        end
    endtask

    task automatic test_reset_in_wait();
        bit seen, stray;
        m_addr[1*ADDR_W +: ADDR_W] = 32'h0000_0200; m_we[1] = 1'b0;
        @(posedge clk); #1;
        m_req = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk); #1;
            if (s_req != '0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstwait_launch: s_req never rose, required 01");
        end
        rst = 1'b1; m_req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (s_req !== '0 || m_ready !== '0) begin
            errors++;
            $display("FAIL rstwait_abandon: s_req=%b m_ready=%b, required 00 000", s_req, m_ready);
        end
        stray = 1'b0;
        s_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            s_ready = '0;
            if (m_ready != '0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rstwait_late_ready: m_ready seen after reset, required none");
        end
        for (int i = 0; i < NUM_M; i++) begin
            t_addr[i] = 32'h1000_0000 + 32'(i * 64); t_we[i] = 1'b0; t_wdata[i] = '0;
        end
        sl_data[1] = rnd_line();
        run_txn(3'b111, 1, 100);
        checks++;
        if (o_rdy_vec[0] !== 3'b001 || o_err[0] !== 3'b000 || o_rdata[0] !== sl_data[1]) begin
            errors++;
            $display("FAIL rstwait_ptr: first ready=%b err=%b rdata=%h, required 001 000 %h",
                     o_rdy_vec[0], o_err[0], o_rdata[0], sl_data[1]);
        end
    endtask

    task automatic test_write();
        logic [DATA_W-1:0] wd;
        wd = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        t_addr[1] = 32'h0000_0100; t_we[1] = 1'b1; t_wdata[1] = wd;
        sl_data[0] = {4{32'hDEAD_BEEF}};
        run_txn(3'b010, 2, 50);
        checks++;
        if (o_sreq[0] !== 2'b01 || o_swe[0] !== 1'b1 || o_swdata[0] !== wd || o_saddr[0] !== 32'h0000_0100) begin
            errors++;
            $display("FAIL write_slave_side: s_req=%b s_we=%b s_addr=%h s_wdata=%h, required 01 1 00000100 %h",
                     o_sreq[0], o_swe[0], o_saddr[0], o_swdata[0], wd);
        end
        checks++;
        if (o_rdy_vec[0] !== 3'b010 || o_err[0] !== 3'b000 || o_rdata[0] !== '0) begin
            errors++;
            $display("FAIL write_resp: ready=%b err=%b rdata=%h, required 010 000 0", o_rdy_vec[0], o_err[0], o_rdata[0]);
        end
        t_we[1] = 1'b0;
    endtask

    task automatic test_random();
        int ptr_m, no, idle, lat, w, hj, cc, exp_first, exp_rdy;
        int order [3];
        logic [NUM_M-1:0] reqs, rem, ev;
        logic [NUM_S-1:0] es;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] exp_rd;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ptr_m = 0;
        for (int it = 0; it < 40; it++) begin
            reqs = NUM_M'($urandom_range(1, 7));
            lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            for (int i = 0; i < NUM_M; i++) begin
                a = $urandom;
                case ($urandom_range(0, 2))
                    0:       a[31:28] = 4'h0;
                    1:       a[31:28] = 4'h1;
                    default: a[31:28] = 4'($urandom_range(2, 15));
                endcase
                t_addr[i] = a; t_we[i] = 1'($urandom_range(0, 1)); t_wdata[i] = rnd_line();
            end
            for (int j = 0; j < NUM_S; j++) sl_data[j] = rnd_line();
            run_txn(reqs, lat, 200);
            // Expected grant order from the round-robin rule.
            rem = reqs; no = 0;
            while (rem != '0) begin
                for (int k = 0; k < NUM_M; k++) begin
                    cc = (ptr_m + k) % NUM_M;
                    if (rem[cc]) begin
                        order[no] = cc; no++; rem[cc] = 1'b0; ptr_m = (cc + 1) % NUM_M;
                        break;
                    end
                end
            end
            checks++;
            if (n_done != no) begin
                errors++;
                $display("FAIL rand_count it%0d: completions=%0d, required %0d", it, n_done, no);
            end
            idle = 0;
            for (int k = 0; k < no && k < n_done; k++) begin
                w = order[k];
                hj = -1;
                for (int j = NUM_S - 1; j >= 0; j--)
                    if ((t_addr[w] & ~(map_size[j] - 1)) == map_base[j]) hj = j;
                ev = '0; ev[w] = 1'b1;
                es = '0;
                exp_first = -1;
                if (hj < 0) begin
                    exp_rdy = idle + 1; exp_rd = '0;
                end else begin
                    es[hj] = 1'b1; exp_first = idle + 1;
                    exp_rdy = (lat < 0) ? idle + TIMEOUT + 1 : idle + lat + 2;
                    exp_rd = (lat < 0 || t_we[w]) ? '0 : sl_data[hj];
                end
                checks++;
                if (o_rdy_vec[k] !== ev || o_err[k] !== ((hj < 0 || lat < 0) ? ev : '0)) begin
                    errors++;
                    $display("FAIL rand_grant it%0d k%0d: ready=%b err=%b, required ready %b", it, k, o_rdy_vec[k], o_err[k], ev);
                end
                checks++;
                if (o_rdy[k] != exp_rdy || o_first[k] != exp_first || o_rdata[k] !== exp_rd) begin
                    errors++;
                    $display("FAIL rand_resp it%0d k%0d: cycle=%0d first=%0d rdata=%h, required %0d %0d %h",
                             it, k, o_rdy[k], o_first[k], o_rdata[k], exp_rdy, exp_first, exp_rd);
                end
                checks++;
                if (o_sreq[k] !== es ||
                    (hj >= 0 && (o_saddr[k] !== t_addr[w] - map_base[hj] || o_swe[k] !== t_we[w] || o_swdata[k] !== t_wdata[w]))) begin
                    errors++;
                    $display("FAIL rand_slave it%0d k%0d: s_req=%b s_addr=%h s_we=%b, required s_req %b",
                             it, k, o_sreq[k], o_saddr[k], o_swe[k], es);
                end
                idle = exp_rdy + 1;
            end
            checks++;
            if (o_glitch) begin
                errors++;
                $display("FAIL rand_stable it%0d: slave outputs changed during WAIT or multi-hot m_ready", it);
            end
        end
    endtask

    initial begin
        map_base[0] = 32'h0000_0000; map_size[0] = 32'h1000_0000;
        map_base[1] = 32'h1000_0000; map_size[1] = 32'h1000_0000;
        for (int i = 0; i < NUM_M; i++) begin
            t_addr[i] = '0; t_we[i] = 1'b0; t_wdata[i] = '0;
        end
        for (int j = 0; j < NUM_S; j++) sl_data[j] = '0;
        test_reset();
        test_read_slave1();
        test_rr_order();
        test_unmapped();
        test_timeout();
        test_reset_in_wait();
        test_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
